// File: rtl/hex_display_sequencer_if.sv
// Avalon-MM write-only bus to the bank of seven-segment PIO slaves.
// The master drives one write per cycle; the PIOs have no waitrequest.
interface hex_display_sequencer_if #(
    parameter int NUM_DIGITS = 6
);
    logic [NUM_DIGITS-1:0] hex_chipselect;
    logic [1:0]            hex_address;
    logic                  hex_write_n;
    logic [31:0]           hex_writedata;

    modport master (
        output hex_chipselect,
        output hex_address,
        output hex_write_n,
        output hex_writedata
    );

    modport slave (
        input hex_chipselect,
        input hex_address,
        input hex_write_n,
        input hex_writedata
    );
endinterface

// File: rtl/hex_display_sequencer.sv
// Round-robin shares a bank of seven-segment PIOs between two requesters,
// writing one decoded digit per cycle after an initial blanking sweep.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_INIT  | blank every digit once after reset, one write per cycle
// S_IDLE  | bus idle, arbitrate pending requests
// S_WRITE | write segment pattern of latched value, digit by digit
// S_ACK   | bus idle, one-cycle ack to grantee, record last grant
module hex_display_sequencer #(
    parameter int NUM_DIGITS = 6,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req0,
    input  logic [4*NUM_DIGITS-1:0] value0,
    output logic                    ack0,
    input  logic                    req1,
    input  logic [4*NUM_DIGITS-1:0] value1,
    output logic                    ack1,
    output logic                    busy,
    hex_display_sequencer_if.master bus
);

    localparam int             VW         = 4 * NUM_DIGITS;
    localparam int             DW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DW-1:0]  LAST_DIGIT = DW'(NUM_DIGITS - 1);
    localparam logic [6:0]     BLANK      = ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_ACK
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DW-1:0]         r_digit;
    logic [DW-1:0]         w_next_digit;
    logic                  r_grant;
    logic                  w_grant;
    logic                  w_load;
    logic                  r_last_grant;
    logic [VW-1:0]         r_value;

    logic [NUM_DIGITS-1:0] r_cs;
    logic                  r_write_n;
    logic [6:0]            r_wdata;
    logic                  r_ack0;
    logic                  r_ack1;
    logic                  r_busy;

    logic [NUM_DIGITS-1:0] w_cs;
    logic                  w_write_n;
    logic [6:0]            w_wdata;
    logic                  w_ack0;
    logic                  w_ack1;

    logic [NUM_DIGITS-1:0] w_onehot;
    logic [3:0]            w_nibble;
    logic                  w_cur_blank;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return ACTIVE_LOW ? s : ~s;
    endfunction

    // Walk from the top nibble down so the "all zero from here up" flag
    // is ready when the current digit is reached.
    always_comb begin
        logic w_tail_zero;
        w_tail_zero = 1'b1;
        w_onehot    = '0;
        w_nibble    = 4'h0;
        w_cur_blank = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_tail_zero = w_tail_zero & (r_value[4*i +: 4] == 4'h0);
            if (r_digit == DW'(i)) begin
                w_onehot[i] = 1'b1;
                w_nibble    = r_value[4*i +: 4];
                w_cur_blank = LZ_BLANK && (i != 0) && w_tail_zero;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_digit = r_digit;
        w_grant      = r_grant;
        w_load       = 1'b0;
        w_cs         = '0;
        w_write_n    = 1'b1;
        w_wdata      = 7'h00;
        w_ack0       = 1'b0;
        w_ack1       = 1'b0;
        case (r_state)
            S_INIT: begin
                w_cs      = w_onehot;
                w_write_n = 1'b0;
                w_wdata   = BLANK;
                if (r_digit == LAST_DIGIT) begin
                    w_next_state = S_IDLE;
                    w_next_digit = '0;
                end else begin
                    w_next_digit = r_digit + DW'(1);
                end
            end
            S_IDLE: begin
                if (req0 || req1) begin
                    w_load       = 1'b1;
                    w_grant      = (req0 && req1) ? ~r_last_grant : req1;
                    w_next_state = S_WRITE;
                    w_next_digit = '0;
                end
            end
            S_WRITE: begin
                w_cs      = w_onehot;
                w_write_n = 1'b0;
                w_wdata   = w_cur_blank ? BLANK : seg7(w_nibble);
                if (r_digit == LAST_DIGIT) begin
                    w_next_state = S_ACK;
                    w_next_digit = '0;
                end else begin
                    w_next_digit = r_digit + DW'(1);
                end
            end
            S_ACK: begin
                w_ack0       = ~r_grant;
                w_ack1       = r_grant;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_INIT;
                w_next_digit = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_INIT;
            r_digit      <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_value      <= '0;
            r_cs         <= '0;
            r_write_n    <= 1'b1;
            r_wdata      <= 7'h00;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            r_state   <= w_next_state;
            r_digit   <= w_next_digit;
            r_grant   <= w_grant;
            if (w_load) begin
                r_value <= w_grant ? value1 : value0;
            end
            if (r_state == S_ACK) begin
                r_last_grant <= r_grant;
            end
            r_cs      <= w_cs;
            r_write_n <= w_write_n;
            r_wdata   <= w_wdata;
            r_ack0    <= w_ack0;
            r_ack1    <= w_ack1;
            r_busy    <= (w_next_state != S_IDLE);
        end
    end

    assign ack0              = r_ack0;
    assign ack1              = r_ack1;
    assign busy              = r_busy;
    assign bus.hex_chipselect = r_cs;
    assign bus.hex_address    = 2'b00;
    assign bus.hex_write_n    = r_write_n;
    assign bus.hex_writedata  = {25'b0, r_wdata};

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Self-checking bench: directed vector table, corner sequences and random
// updates compared against a digit-level model of the display rules.
module tb_hex_display_sequencer;

    localparam int N  = 6;
    localparam int VW = 4 * N;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, ack0, ack1, busy;
    logic [VW-1:0] value0 = '0, value1 = '0;
    logic          req0b = 1'b0, req1b = 1'b0, ack0b, ack1b, busyb;
    logic [VW-1:0] value0b = '0, value1b = '0;

    hex_display_sequencer_if #(.NUM_DIGITS(N)) bus_a ();
    hex_display_sequencer_if #(.NUM_DIGITS(N)) bus_b ();

    hex_display_sequencer #(.NUM_DIGITS(N), .ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .value0(value0), .ack0(ack0),
        .req1(req1), .value1(value1), .ack1(ack1),
        .busy(busy), .bus(bus_a)
    );

    hex_display_sequencer #(.NUM_DIGITS(N), .ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)) u_dut_nolz (
        .clk(clk), .reset_n(reset_n),
        .req0(req0b), .value0(value0b), .ack0(ack0b),
        .req1(req1b), .value1(value1b), .ack1(ack1b),
        .busy(busyb), .bus(bus_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] cs;
        logic [6:0]   d;
    } wr_t;

    typedef struct {
        bit            who;
        logic [VW-1:0] v;
        logic [7*N-1:0] exp;   // {d5, ..., d0}
    } vec_t;

    wr_t         wq_a[$];
    wr_t         wq_b[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int          n_ack0 = 0, n_ack1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!bus_a.hex_write_n) wq_a.push_back({bus_a.hex_chipselect, bus_a.hex_writedata[6:0]});
        if (!bus_b.hex_write_n) wq_b.push_back({bus_b.hex_chipselect, bus_b.hex_writedata[6:0]});
        if (ack0) n_ack0 <= n_ack0 + 1;
        if (ack1) n_ack1 <= n_ack1 + 1;
        tests++;
        if (bus_a.hex_address != 2'b00 || bus_a.hex_writedata[31:7] != 25'b0 ||
            (bus_a.hex_write_n && bus_a.hex_chipselect != '0) ||
            (!bus_a.hex_write_n && !$onehot(bus_a.hex_chipselect)) || (ack0 && ack1)) begin
            fails++;
            $display("FAIL bus protocol @%0t: cs=%b wn=%b addr=%0d wdata=%h ack=%b%b, required legal bus",
                     $time, bus_a.hex_chipselect, bus_a.hex_write_n, bus_a.hex_address,
                     bus_a.hex_writedata, ack1, ack0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_al(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Digit i > 0 goes blank when the value shifted down by i nibbles is zero.
    task automatic build_exp(input logic [VW-1:0] v, input bit lz, output logic [6:0] e [N]);
        for (int i = 0; i < N; i++) begin
            if (lz && i > 0 && (v >> (4 * i)) == '0) e[i] = 7'h7F;
            else                                     e[i] = seg_al(v[4*i +: 4]);
        end
    endtask

    task automatic check_digits(input string name, input bit use_b, input logic [6:0] e [N]);
        wr_t          w;
        logic [N-1:0] one;
        for (int i = 0; i < N; i++) begin
            one = N'(1) << i;
            if ((use_b ? wq_b.size() : wq_a.size()) == 0) begin
                tests++;
                fails++;
                $display("FAIL %s d%0d: no write seen, expected cs=%b data=%02h", name, i, one, e[i]);
            end else begin
                if (use_b) w = wq_b.pop_front();
                else       w = wq_a.pop_front();
                check($sformatf("%s d%0d cs", name, i), 32'(w.cs), 32'(one));
                check($sformatf("%s d%0d data", name, i), 32'(w.d), 32'(e[i]));
            end
        end
    endtask

    task automatic init_sweep(input string name);
        logic [6:0] e [N];
        bit         done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        check({name, " busy falls"}, 32'(done), 32'd1);
        @(negedge clk);
        for (int i = 0; i < N; i++) e[i] = 7'h7F;
        check_digits(name, 1'b0, e);
        check({name, " no extra writes"}, wq_a.size(), 0);
    endtask

    task automatic run_txn(input string name, input bit who, input logic [VW-1:0] v,
                           input logic [6:0] e [N], input bit late, input logic [VW-1:0] v_late);
        int unsigned c0;
        bit          got = 1'b0, other = 1'b0;
        @(negedge clk);
        wq_a.delete();
        if (who) begin value1 = v; req1 = 1'b1; end
        else     begin value0 = v; req0 = 1'b1; end
        c0 = cyc;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (late && k == 0) begin
                if (who) value1 = v_late;
                else     value0 = v_late;
            end
            if (who ? ack0 : ack1) other = 1'b1;
            if (who ? ack1 : ack0) begin
                got = 1'b1;
                if (who) req1 = 1'b0;
                else     req0 = 1'b0;
                check({name, " latency"}, cyc - c0, N + 2);
            end
        end
        check({name, " ack seen"}, 32'(got), 32'd1);
        check({name, " wrong ack"}, 32'(other), 32'd0);
        @(negedge clk);
        check({name, " ack width"}, 32'(who ? ack1 : ack0), 32'd0);
        check_digits(name, 1'b0, e);
        check({name, " no extra writes"}, wq_a.size(), 0);
    endtask

    vec_t          vecs [6];
    logic [6:0]    e [N];
    int            nacks, gseq [4], nw, a0, k6;
    int unsigned   gcyc [4];
    bit            got, who;
    logic [VW-1:0] v, m;

    initial begin
        vecs[0] = '{1'b0, 24'h00012A, {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h08}};
        vecs[1] = '{1'b1, 24'h000000, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[2] = '{1'b0, 24'hFEDCBA, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}};
        vecs[3] = '{1'b1, 24'h100000, {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[4] = '{1'b0, 24'h003000, {7'h7F, 7'h7F, 7'h30, 7'h40, 7'h40, 7'h40}};
        vecs[5] = '{1'b1, 24'h987654, {7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19}};

        // Reset values
        repeat (3) @(negedge clk);
        check("reset cs", 32'(bus_a.hex_chipselect), 32'd0);
        check("reset write_n", 32'(bus_a.hex_write_n), 32'd1);
        check("reset address", 32'(bus_a.hex_address), 32'd0);
        check("reset wdata", bus_a.hex_writedata, 32'd0);
        check("reset ack0", 32'(ack0), 32'd0);
        check("reset ack1", 32'(ack1), 32'd0);
        check("reset busy", 32'(busy), 32'd1);
        wq_a.delete();
        reset_n = 1'b1;
        init_sweep("init");
        check("init no ack0", n_ack0, 0);
        check("init no ack1", n_ack1, 0);

        // Both requesters held from the first IDLE: 0 wins first, then alternate
        @(negedge clk);
        wq_a.delete();
        value0 = 24'h00012A;
        value1 = 24'h000000;
        req0 = 1'b1;
        req1 = 1'b1;
        nacks = 0;
        for (int k = 0; k < 60 && nacks < 4; k++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                gseq[nacks] = ack1 ? 1 : 0;
                gcyc[nacks] = cyc;
                nacks++;
                if (nacks == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        check("arb ack count", nacks, 4);
        for (int i = 0; i < nacks; i++) check($sformatf("arb grant%0d", i), gseq[i], i % 2);
        for (int i = 1; i < nacks; i++) check($sformatf("arb gap%0d", i), gcyc[i] - gcyc[i-1], N + 2);
        @(negedge clk);
        for (int i = 0; i < nacks; i++) begin
            build_exp((i % 2) ? value1 : value0, 1'b1, e);
            check_digits($sformatf("arb txn%0d", i), 1'b0, e);
        end
        check("arb no extra writes", wq_a.size(), 0);

        // Directed table
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) e[i] = vecs[t].exp[7*i +: 7];
            run_txn($sformatf("vec%0d", t), vecs[t].who, vecs[t].v, e, 1'b0, '0);
        end

        // Value changes right after grant must not reach the display
        for (int i = 0; i < N; i++) e[i] = 7'h79;
        run_txn("late value", 1'b0, 24'h111111, e, 1'b1, 24'hFFFFFF);

        // Random values with a random number of leading zero nibbles
        for (int t = 0; t < 24; t++) begin
            k6  = $urandom_range(0, 6);
            m   = {VW{1'b1}} >> (4 * k6);
            v   = VW'($urandom) & m;
            who = 1'($urandom_range(0, 1));
            build_exp(v, 1'b1, e);
            run_txn($sformatf("rand%0d", t), who, v, e, 1'b0, '0);
        end

        // Reset in the third WRITE cycle, request stays pending
        @(negedge clk);
        value0 = 24'h123456;
        req0   = 1'b1;
        nw     = 0;
        a0     = n_ack0;
        for (int k = 0; k < 20 && nw < 2; k++) begin
            @(negedge clk);
            if (!bus_a.hex_write_n) nw++;
        end
        check("abort writes before reset", nw, 2);
        reset_n = 1'b0;
        #1;
        check("abort cs", 32'(bus_a.hex_chipselect), 32'd0);
        check("abort write_n", 32'(bus_a.hex_write_n), 32'd1);
        check("abort busy", 32'(busy), 32'd1);
        check("abort ack0", 32'(ack0), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wq_a.delete();
        init_sweep("reinit");
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (ack0) begin got = 1'b1; req0 = 1'b0; end
        end
        check("pending ack", 32'(got), 32'd1);
        @(negedge clk);
        check("pending ack count", n_ack0 - a0, 1);
        build_exp(24'h123456, 1'b1, e);
        check_digits("pending", 1'b0, e);

        // Instance without leading-zero suppression
        for (int t = 0; t < 2; t++) begin
            v = (t == 0) ? 24'h000000 : 24'h000A00;
            @(negedge clk);
            wq_b.delete();
            value0b = v;
            req0b   = 1'b1;
            got     = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                if (ack0b) begin got = 1'b1; req0b = 1'b0; end
            end
            check($sformatf("nolz%0d ack", t), 32'(got), 32'd1);
            @(negedge clk);
            build_exp(v, 1'b0, e);
            check_digits($sformatf("nolz%0d", t), 1'b1, e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hex_display_sequencer.md
Name: hex_display_sequencer

Overview:
- Avalon-MM write-only master that shares the bank of seven-segment PIO slaves (HEX0..HEXn, 7-bit `data_out` at address 0) between two requesters, e.g. accelerometer datapath and Nios override.
- Arbitrates requests round-robin, decodes the granted hex value nibble-by-nibble to segment patterns, and writes one digit per cycle to the matching PIO.
- After reset it blanks all displays, because the PIOs reset to 0, which lights every segment on active-low boards.

Parameters:
- NUM_DIGITS, 6, number of HEX PIO slaves driven (1..8); value width is 4*NUM_DIGITS.
- ACTIVE_LOW, 1, 1 = segment on when bit is 0 (bit0=a ... bit6=g).
- LZ_BLANK, 1, 1 = suppress leading zeros; digit 0 is never blanked.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 update request; held until ack0.
- value0  in  4*NUM_DIGITS  requester 0 hex value; stable while req0 high.
- ack0  out  1  one-cycle completion pulse to requester 0.
- req1  in  1  requester 1 update request.
- value1  in  4*NUM_DIGITS  requester 1 hex value.
- ack1  out  1  one-cycle completion pulse to requester 1.
- busy  out  1  high in every state except IDLE.
- hex_chipselect  out  NUM_DIGITS  one-hot select; bit i drives HEXi chipselect.
- hex_address  out  2  always 0.
- hex_write_n  out  1  active-low write strobe.
- hex_writedata  out  32  {25'b0, segment pattern}.

Behaviour:
- Reset (async, all registered):
  - hex_chipselect=0, hex_write_n=1, hex_address=0, hex_writedata=0.
  - ack0=ack1=0, busy=1.
  - state=INIT, digit=0, last_grant=1, so req0 wins the first tie.
- Reset asserted mid-sweep aborts immediately. Partially written digits are not restored; INIT re-blanks all digits.
- INIT:
  - Writes the blank pattern to digits 0..NUM_DIGITS-1, one per cycle. Blank is 7'h7F if ACTIVE_LOW, else 7'h00.
  - Goes to IDLE after the last digit. Requests are ignored (not lost, just held) during INIT.
- IDLE: busy=0, bus idle. On a clock edge with any req high:
  - Only one req: grant that requester.
  - Both req: grant the one not equal to last_grant.
  - Latch the value into an internal register, compute the blank mask, set digit=0, go WRITE.
- WRITE:
  - Each cycle, hex_chipselect = 1<<digit, hex_write_n=0, hex_writedata[6:0] = seg(nibble digit), or the blank pattern if masked.
  - Exactly one write per digit; the PIOs have no waitrequest.
  - digit increments; after digit NUM_DIGITS-1, go ACK.
- ACK:
  - Bus idle; pulse ack for the granted requester for exactly one cycle.
  - last_grant = grantee; return to IDLE.
  - A requester must drop req on the edge where it samples ack=1. Otherwise it is re-serviced.
- Latency: req sampled at edge E → first write registered at E+1 → last write at E+NUM_DIGITS → ack high during cycle E+NUM_DIGITS+1. Throughput is one update per NUM_DIGITS+2 cycles.
- Bus outputs are registered; write_n and chipselect always change together.
- Segment encoding, active-low, hex 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E. With ACTIVE_LOW=0, use the bitwise inverse of 7 bits.
- Leading-zero blanking:
  - Digit i>0 is blanked iff every nibble i..NUM_DIGITS-1 is 0. The mask is computed from the latched value.
  - Value 0 shows a single "0" on digit 0.
- Value changes while req is high and not yet granted are allowed. The value is captured at grant; changes after grant have no effect.
- A new req arriving during WRITE/ACK waits; arbitration happens only in IDLE.

Test Plan:
- Reset release, no req → 6 consecutive writes, chipselect 01,02,04,08,10,20, writedata 0x7F each; busy falls in the cycle after the last write; no ack.
- req0, value0=24'h00012A → writes 0x08, 0x24, 0x79, then 0x7F ×3; ack0 one cycle at E+7; ack1 never.
- req0 and req1 both high in the first IDLE → req0 served first (last_grant reset=1), then req1 immediately after with no extra idle cycle; with both held, grants alternate 0,1,0,1.
- value1=0, LZ_BLANK=1 → digit0=0x40, digits 1-5=0x7F; with LZ_BLANK=0 all six=0x40.
- reset_n low during 3rd WRITE cycle → bus outputs inactive asynchronously, no ack; after release INIT sweep repeats, then the pending req is serviced.
- value0 changes after grant (24'h111111→24'hFFFFFF) → all writes show 0x79.
